pow8_rr_sched: RTL and testbench

Round-robin scheduler that lets NUM_REQ requesters share one in-order ready/valid compute engine (the 32-bit-in / 64-bit-out pow8 pipeline with its output skid).
- Forward path: arbitrates requests into the engine and records the issuing requester's ID in an in-order tag FIFO.
- Return path: steers each engine result back to the requester whose ID is at the FIFO head.
- Bounds outstanding transactions to MAX_OUT.

---
 rtl/pow8_rr_sched_pkg.sv | 15 +
 rtl/pow8_rr_sched_if.sv | 35 +++
 rtl/pow8_tag_fifo.sv | 58 +++++
 rtl/pow8_rr_sched.sv | 123 ++++++++++++
 tb/tb_pow8_rr_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pow8_rr_sched_pkg.sv
// Shared defaults and lock-FSM encoding for the pow8 round-robin scheduler.
package pow8_rr_sched_pkg;

    localparam int unsigned NUM_REQ_D = 4;
    localparam int unsigned ID_W_D    = 2;
    localparam int unsigned DW_IN_D   = 32;
    localparam int unsigned DW_OUT_D  = 64;
    localparam int unsigned MAX_OUT_D = 8;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/pow8_rr_sched_if.sv
// Requester, engine and response handshake bundle; slave is the scheduler side.
interface pow8_rr_sched_if
    import pow8_rr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_D,
    parameter int unsigned ID_W    = ID_W_D,
    parameter int unsigned DW_IN   = DW_IN_D,
    parameter int unsigned DW_OUT  = DW_OUT_D
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*DW_IN-1:0] req_data;
    logic                     eng_valid;
    logic                     eng_ready;
    logic [DW_IN-1:0]         eng_data;
    logic                     res_valid;
    logic                     res_ready;
    logic [DW_OUT-1:0]        res_data;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [DW_OUT-1:0]        rsp_data;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req_valid, req_data, eng_ready, res_valid, res_data, rsp_ready,
        input  req_ready, eng_valid, eng_data, res_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, eng_ready, res_valid, res_data, rsp_ready,
        output req_ready, eng_valid, eng_data, res_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/pow8_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every in-flight transaction.
module pow8_tag_fifo
    import pow8_rr_sched_pkg::*;
#(
    parameter int unsigned W     = ID_W_D,
    parameter int unsigned DEPTH = MAX_OUT_D
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/pow8_rr_sched.sv
// Round-robin scheduler sharing one in-order pow8 engine among NUM_REQ requesters.
module pow8_rr_sched
    import pow8_rr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_D,
    parameter int unsigned ID_W    = ID_W_D,
    parameter int unsigned DW_IN   = DW_IN_D,
    parameter int unsigned DW_OUT  = DW_OUT_D,
    parameter int unsigned MAX_OUT = MAX_OUT_D
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pow8_rr_sched_if.slave           bus,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_underflow
);

    lock_state_e     state;
    lock_state_e     state_nxt;
    logic [ID_W-1:0] lock_id;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] arb_grant;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] head;
    logic [ID_W:0]   idx;
    logic            found;
    logic            any_req;
    logic            can_issue;
    logic            issue;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            nonempty;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        arb_grant = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
                found     = 1'b1;
                arb_grant = idx[ID_W-1:0];
            end
        end
    end

    assign any_req   = |bus.req_valid;
    assign can_issue = ~fifo_full;
    assign grant     = (state == LOCKED) ? lock_id : arb_grant;
    assign issue     = bus.eng_valid & bus.eng_ready;

    always_comb begin
        bus.eng_valid = (any_req | (state == LOCKED)) & can_issue;
        bus.eng_data  = '0;
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                bus.eng_data     = bus.req_data[i*DW_IN +: DW_IN];
                bus.req_ready[i] = bus.eng_valid & bus.eng_ready;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (bus.eng_valid & ~bus.eng_ready) state_nxt = LOCKED;
            LOCKED:   if (issue)                          state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= UNLOCKED;
            lock_id       <= '0;
            rr_ptr        <= '0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == UNLOCKED && state_nxt == LOCKED) lock_id <= grant;
            if (issue) rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
            if (bus.res_valid & ~nonempty) err_underflow <= 1'b1;
        end
    end

    pow8_tag_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (issue),
        .pop     (pop),
        .din     (grant),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding)
    );

    assign nonempty = ~fifo_empty;

    // Return path: only the requester at the FIFO head sees the result.
    always_comb begin
        bus.rsp_valid = '0;
        bus.res_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (head == ID_W'(i)) begin
                bus.rsp_valid[i] = bus.res_valid & nonempty;
                bus.res_ready    = bus.rsp_ready[i] & nonempty;
            end
        end
    end

    assign bus.rsp_data = bus.res_data;
    assign bus.rsp_id   = head;
    assign pop          = bus.res_valid & bus.res_ready;

endmodule

// File: tb/tb_pow8_rr_sched.sv
// Self-checking bench for pow8_rr_sched: directed steps then randomized traffic against a queue model.
module tb_pow8_rr_sched;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int DWI  = 32;
    localparam int DWO  = 64;
    localparam int MAXO = 8;

    logic       clk;
    logic       reset_n;
    logic       clk_run;
    logic [3:0] outstanding;
    logic       err_underflow;

    int unsigned total;
    int unsigned bad;

    // Reference model state
    int           m_rr;
    bit           m_lock;
    int           m_lock_id;
    int           m_q[$];
    logic [31:0]  eng_q[$];
    bit           m_err;
    int           acc_id;

    bit [N-1:0]   pend;

    pow8_rr_sched_if #(.NUM_REQ(N), .ID_W(IDW), .DW_IN(DWI), .DW_OUT(DWO)) bus ();

    pow8_rr_sched #(
        .NUM_REQ (N),
        .ID_W    (IDW),
        .DW_IN   (DWI),
        .DW_OUT  (DWO),
        .MAX_OUT (MAXO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [63:0] pow8(input logic [31:0] x);
        logic [63:0] p;
        p = {32'd0, x};
        p = p * p;
        p = p * p;
        p = p * p;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_lock = 0;
        m_lock_id = 0;
        m_q.delete();
        eng_q.delete();
        m_err = 0;
    endtask

    // One clock: check combinational outputs against the model, then advance it.
    task automatic cyc();
        int g;
        bit found, any, can, ev, ne, iss, pp, und;
        int head;
        logic [31:0] d;
        #1;
        any = |bus.req_valid;
        can = m_q.size() < MAXO;
        g = 0;
        found = 0;
        if (m_lock) g = m_lock_id;
        else begin
            for (int k = 0; k < N; k++) begin
                if (!found && bus.req_valid[(m_rr + k) % N]) begin
                    found = 1;
                    g = (m_rr + k) % N;
                end
            end
        end
        ev = (any || m_lock) && can;
        ne = m_q.size() != 0;
        head = ne ? m_q[0] : 0;
        d = bus.req_data[g*DWI +: DWI];
        chk("eng_valid", bus.eng_valid, ev);
        if (ev) chk("eng_data", bus.eng_data, d);
        chk("req_ready", bus.req_ready, (ev && bus.eng_ready) ? (64'd1 << g) : 64'd0);
        chk("rsp_valid", bus.rsp_valid, (bus.res_valid && ne) ? (64'd1 << head) : 64'd0);
        chk("res_ready", bus.res_ready, ne && bus.rsp_ready[head]);
        if (ne) chk("rsp_id", bus.rsp_id, head);
        chk("rsp_data", bus.rsp_data, bus.res_data);
        chk("outstanding", outstanding, m_q.size());
        chk("err_underflow", err_underflow, m_err);
        iss = ev && bus.eng_ready;
        pp  = bus.res_valid && ne && bus.rsp_ready[head];
        und = bus.res_valid && !ne;
        acc_id = iss ? g : -1;
        @(posedge clk);
        if (pp) begin
            void'(m_q.pop_front());
            void'(eng_q.pop_front());
        end
        if (iss) begin
            m_q.push_back(g);
            eng_q.push_back(d);
            m_rr = (g + 1) % N;
            m_lock = 0;
        end else if (ev && !m_lock) begin
            m_lock = 1;
            m_lock_id = g;
        end
        if (und) m_err = 1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.eng_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_eng_valid", bus.eng_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int n = 0; n < 40 && eng_q.size() > 0; n++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = pow8(eng_q[0]);
            cyc();
        end
        bus.res_valid = 1'b0;
        #1;
        chk("drain_done", outstanding, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        acc_id = -1;
        pend = '0;
        clk_run = 1'b1;
        reset_n = 1'b0;
        bus.req_data = '0;
        idle_inputs();
        model_reset();
        #1;
        chk("reset_eng_valid", bus.eng_valid, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_res_ready", bus.res_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_err", err_underflow, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single request round trip
        bus.req_data[0 +: 32] = 32'd3;
        bus.req_valid = 4'b0001;
        bus.eng_ready = 1'b1;
        #1;
        chk("t1_eng_data", bus.eng_data, 3);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("t1_out1", outstanding, 1);
        bus.res_valid = 1'b1;
        bus.res_data  = 64'd6561;
        bus.rsp_ready = 4'b0001;
        #1;
        chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t1_rsp_data", bus.rsp_data, 64'd6561);
        chk("t1_rsp_id", bus.rsp_id, 0);
        cyc();
        bus.res_valid = 1'b0;
        #1;
        chk("t1_out0", outstanding, 0);

        // 2: all requesters valid, rotating grants and in-order returns
        do_reset();
        for (int i = 0; i < N; i++) bus.req_data[i*32 +: 32] = 32'h100 + i;
        bus.req_valid = '1;
        bus.eng_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("t2_grant", bus.req_ready, 64'd1 << (n % 4));
            cyc();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int n = 0; n < 6; n++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = pow8(eng_q[0]);
            #1;
            chk("t2_rsp_id", bus.rsp_id, n % 4);
            cyc();
        end
        bus.res_valid = 1'b0;

        // 3: stall locks the grant against a higher-priority arrival
        do_reset();
        bus.req_data[0 +: 32]  = 32'h1000_0000;
        bus.req_data[64 +: 32] = 32'h2222_0002;
        bus.req_valid = 4'b0100;
        bus.eng_ready = 1'b0;
        for (int n = 0; n < 3; n++) cyc();
        bus.req_valid = 4'b0101;
        #1;
        chk("t3_locked_data", bus.eng_data, 32'h2222_0002);
        cyc();
        bus.eng_ready = 1'b1;
        #1;
        chk("t3_accept2", bus.req_ready, 4'b0100);
        cyc();
        bus.req_valid = 4'b0001;
        #1;
        chk("t3_next0", bus.req_ready, 4'b0001);
        cyc();
        drain();

        // 4: MAX_OUT bound; a pop does not free a push slot in the same cycle
        do_reset();
        bus.req_valid = '1;
        bus.eng_ready = 1'b1;
        for (int n = 0; n < MAXO; n++) cyc();
        #1;
        chk("t4_full_out", outstanding, MAXO);
        chk("t4_full_ready", bus.req_ready, 0);
        cyc();
        bus.res_valid = 1'b1;
        bus.res_data  = pow8(eng_q[0]);
        bus.rsp_ready = '1;
        #1;
        chk("t4_pop_noready", bus.req_ready, 0);
        cyc();
        bus.res_valid = 1'b0;
        #1;
        chk("t4_after_pop", outstanding, MAXO - 1);
        chk("t4_push_next", bus.req_ready != 0, 1);
        cyc();
        drain();

        // 5: only the head requester's rsp_ready can pop
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data[32 +: 32] = 32'd2;
        bus.eng_ready = 1'b1;
        cyc();
        bus.req_valid = '0;
        bus.res_valid = 1'b1;
        bus.res_data  = pow8(32'd2);
        bus.rsp_ready = 4'b1101;
        #1;
        chk("t5_res_ready0", bus.res_ready, 0);
        chk("t5_rsp_valid", bus.rsp_valid, 4'b0010);
        cyc();
        bus.rsp_ready = 4'b1111;
        #1;
        chk("t5_res_ready1", bus.res_ready, 1);
        cyc();
        bus.res_valid = 1'b0;
        #1;
        chk("t5_popped", outstanding, 0);

        // 6: sticky underflow, then async reset with the clock stopped
        bus.res_valid = 1'b1;
        bus.res_data  = 64'hdead;
        #1;
        chk("t6_undf_ready", bus.res_ready, 0);
        cyc();
        bus.res_valid = 1'b0;
        #1;
        chk("t6_err_set", err_underflow, 1);
        cyc();
        chk("t6_err_sticky", err_underflow, 1);
        for (int i = 0; i < N; i++) bus.req_data[i*32 +: 32] = 32'hA0 + i;
        bus.req_valid = '1;
        bus.eng_ready = 1'b1;
        for (int n = 0; n < 5; n++) cyc();
        chk("t6_out5", outstanding, 5);
        clk_run = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_err", err_underflow, 0);
        chk("t6_rst_grant0", bus.eng_data, 32'hA0);
        chk("t6_rst_ready0", bus.req_ready, 4'b0001);
        chk("t6_clk_stopped", clk, 0);
        idle_inputs();
        #3;
        reset_n = 1'b1;
        clk_run = 1'b1;
        @(negedge clk);

        // 7: randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    bus.req_data[i*32 +: 32] = $urandom;
                end
            end
            bus.req_valid = pend;
            bus.eng_ready = ($urandom_range(0, 3) != 0);
            bus.rsp_ready = 4'($urandom);
            bus.res_valid = (eng_q.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.res_data  = (eng_q.size() > 0) ? pow8(eng_q[0]) : {$urandom, $urandom};
            cyc();
            if (acc_id >= 0) pend[acc_id] = 1'b0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
